// File: rtl/mul_div_seq.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and restoring divider.
// One iteration per clock; the result lands in {hi,lo} with a one-cycle done pulse.
module mul_div_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [32:0] acc;     // Booth upper accumulator, or partial remainder
  logic [31:0] qr;      // multiplier bits, or dividend/quotient shift register
  logic        qm1;
  logic [32:0] m;       // sign-extended multiplicand, or zero-extended |divisor|
  logic        neg_q;
  logic        neg_r;

  logic [32:0] acc_add;
  logic [32:0] mul_acc_nx;
  logic [31:0] mul_q_nx;
  logic        mul_qm1_nx;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [32:0] rem_nx;
  logic [31:0] div_q_nx;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // NOTE: always_comb gives every output a default first, so no path infers a latch.
  always_comb begin
    acc_add = acc;
    case ({qr[0], qm1})
      2'b01:   acc_add = acc + m;
      2'b10:   acc_add = acc - m;
      default: acc_add = acc;
    endcase
    {mul_acc_nx, mul_q_nx, mul_qm1_nx} = {acc_add[32], acc_add, qr};

    rem_sh = {acc[31:0], qr[31]};
    diff   = rem_sh - m;
    if (!diff[32]) begin
      rem_nx   = diff;
      div_q_nx = {qr[30:0], 1'b1};
    end else begin
      rem_nx   = rem_sh;
      div_q_nx = {qr[30:0], 1'b0};
    end

    quot_fix = neg_q ? (32'd0 - qr) : qr;
    rem_fix  = neg_r ? (32'd0 - acc[31:0]) : acc[31:0];

    // The most negative value maps onto itself, which is 2^31 read as unsigned.
    a_mag = operand_a[31] ? (32'd0 - operand_a) : operand_a;
    b_mag = operand_b[31] ? (32'd0 - operand_b) : operand_b;
  end

  assign busy = (state == MUL) || (state == DIV) || (state == FIX);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      cnt         <= 6'd0;
      acc         <= 33'd0;
      qr          <= 32'd0;
      qm1         <= 1'b0;
      m           <= 33'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt         <= 6'd32;
            div_by_zero <= 1'b0;
            acc         <= 33'd0;
            qm1         <= 1'b0;
            if (!op) begin
              qr    <= operand_b;
              m     <= {operand_a[31], operand_a};
              state <= MUL;
            end else if (operand_b == 32'd0) begin
              hi          <= operand_a;
              lo          <= 32'hFFFF_FFFF;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              qr    <= a_mag;
              m     <= {1'b0, b_mag};
              neg_q <= operand_a[31] ^ operand_b[31];
              neg_r <= operand_a[31];
              state <= DIV;
            end
          end
        end
        MUL: begin
          acc <= mul_acc_nx;
          qr  <= mul_q_nx;
          qm1 <= mul_qm1_nx;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            hi    <= mul_acc_nx[31:0];
            lo    <= mul_q_nx;
            state <= DONE;
          end
        end
        DIV: begin
          acc <= rem_nx;
          qr  <= div_q_nx;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= FIX;
        end
        FIX: begin
          hi    <= rem_fix;
          lo    <= quot_fix;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
